// File: rtl/mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_n_counter
// Purpose  : Runtime-programmable modulo-N up/down counter with enable,
//            synchronous clear, range-checked parallel load, combinational
//            terminal count for cascading, and registered wrap / load-error
//            pulses.
// Revision : 1.0 - initial release
// ============================================================================
module mod_n_counter #(
  parameter int WIDTH       = 3,
  parameter int DEFAULT_MOD = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] modulus,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // A DEFAULT_MOD of 2^WIDTH truncates to 0, which is the encoding of 2^WIDTH.
  localparam logic [WIDTH-1:0] DEFAULT_MOD_ENC = DEFAULT_MOD[WIDTH-1:0];
  localparam logic [WIDTH:0]   FULL_M          = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   ONE_X           = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q,    count_d;
  logic [WIDTH-1:0] modulus_q,  modulus_d;
  logic             wrap_q,     wrap_d;
  logic             load_err_q, load_err_d;

  // Effective modulus and limit are held one bit wider so M-1 cannot overflow.
  logic [WIDTH:0] m_eff;
  logic [WIDTH:0] m_minus1;
  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] count_inc;
  logic [WIDTH:0] count_dec;
  logic           at_top;     // count has reached or passed M-1
  logic           above_top;  // count is out of range after a modulus shrink
  logic           at_zero;

  // Derive the effective modulus and the comparisons used by both tc and the step.
  always_comb begin
    m_eff     = (modulus_q == '0) ? FULL_M : {1'b0, modulus_q};
    m_minus1  = m_eff - ONE_X;
    count_ext = {1'b0, count_q};
    load_ext  = {1'b0, load_val};
    count_inc = count_ext + ONE_X;
    count_dec = count_ext - ONE_X;
    at_top    = (count_ext >= m_minus1);
    above_top = (count_ext >  m_minus1);
    at_zero   = (count_q == '0);
  end

  // Next-state: clear beats load beats counting; modulus write is independent.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    modulus_d  = mod_wr ? mod_val : modulus_q;

    if (clr) begin
      count_d = '0;
    end else if (load) begin
      // Checked against the modulus in force before any same-edge write.
      if (load_ext < m_eff) begin
        count_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        if (at_top) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_inc[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
          count_d = m_minus1[WIDTH-1:0];
          wrap_d  = 1'b1;
        end else if (above_top) begin
          // Re-enter the legal range from the top without flagging a wrap.
          count_d = m_minus1[WIDTH-1:0];
        end else begin
          count_d = count_dec[WIDTH-1:0];
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      modulus_q  <= DEFAULT_MOD_ENC;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      modulus_q  <= modulus_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // Terminal count is deliberately not masked by clr/load so stages can cascade.
  assign tc       = en & (up_dn ? at_top : at_zero);
  assign count    = count_q;
  assign modulus  = modulus_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_n_counter
// Purpose  : Self-checking bench for mod_n_counter: directed scenarios with
//            literal expectations, randomized traffic against a behavioural
//            model, and a two-stage decade cascade.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_n_counter;

  localparam int W  = 3;
  localparam int DM = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0, mod_wr = 1'b0;
  logic [W-1:0] load_val = '0, mod_val = '0;
  logic [W-1:0] count, modulus;
  logic         tc, wrap, load_err;

  // cascade signals
  logic         cas_en = 1'b0;
  logic [3:0]   lo_count, lo_mod, hi_count, hi_mod;
  logic         lo_tc, lo_wrap, lo_lerr, hi_tc, hi_wrap, hi_lerr;
  int           hi_wraps = 0;
  logic         cas_run = 1'b0;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  mod_n_counter #(.WIDTH(W), .DEFAULT_MOD(DM)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .mod_wr(mod_wr), .mod_val(mod_val),
    .count(count), .modulus(modulus), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  mod_n_counter #(.WIDTH(4), .DEFAULT_MOD(10)) u_lo (
    .clk(clk), .reset(reset), .en(cas_en), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .mod_wr(1'b0), .mod_val(4'd0),
    .count(lo_count), .modulus(lo_mod), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_lerr)
  );

  mod_n_counter #(.WIDTH(4), .DEFAULT_MOD(10)) u_hi (
    .clk(clk), .reset(reset), .en(lo_tc), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .mod_wr(1'b0), .mod_val(4'd0),
    .count(hi_count), .modulus(hi_mod), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_lerr)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers, effective modulus kept as 1..2^W.
  int m_cnt = 0;
  int m_M   = DM;
  bit m_wrap = 1'b0, m_lerr = 1'b0;
  bit nw, nl;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_M = DM; m_wrap = 0; m_lerr = 0;
    end else begin
      nw = 0; nl = 0;
      if (clr) m_cnt = 0;
      else if (load) begin
        if (int'(load_val) < m_M) m_cnt = int'(load_val);
        else nl = 1;
      end else if (en) begin
        if (up_dn) begin
          if (m_cnt >= m_M - 1) begin m_cnt = 0; nw = 1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_cnt = m_M - 1; nw = 1; end
          else if (m_cnt > m_M - 1) m_cnt = m_M - 1;
          else m_cnt = m_cnt - 1;
        end
      end
      if (mod_wr) m_M = (mod_val == 0) ? (1 << W) : int'(mod_val);
      m_wrap = nw; m_lerr = nl;
    end
  end

  // Compare the DUT against the model mid-cycle, every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("count", int'(count), m_cnt);
      chk("modulus", int'(modulus), m_M % (1 << W));
      chk("wrap", int'(wrap), int'(m_wrap));
      chk("load_err", int'(load_err), int'(m_lerr));
      chk("tc", int'(tc), int'(en && (up_dn ? (m_cnt >= m_M - 1) : (m_cnt == 0))));
    end
    if (cas_run && hi_wrap) hi_wraps++;
  end

  task automatic drive(input bit e, input bit u, input bit c, input bit l,
                       input int lv, input bit mw, input int mv);
    en = e; up_dn = u; clr = c; load = l;
    load_val = W'(lv); mod_wr = mw; mod_val = W'(mv);
  endtask

  task automatic idle();
    drive(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    tick();
    chk_on = 1'b1;
    chk("reset_count", int'(count), 0);
    chk("reset_modulus", int'(modulus), 5);
    reset = 1'b1;

    // Reset/default: up count through M=5
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("tc_at0", int'(tc), 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("up_seq", int'(count), i);
    end
    chk("tc_at4", int'(tc), 1);
    tick();
    chk("wrap_to0", int'(count), 0);
    chk("wrap_pulse", int'(wrap), 1);
    tick();
    chk("after_wrap", int'(count), 1);
    chk("wrap_clear", int'(wrap), 0);
    tick(); tick();
    chk("at3", int'(count), 3);
    reset = 1'b0;
    #1;
    chk("async_reset", int'(count), 0);
    idle();
    #1 reset = 1'b1;

    // Down count from 2
    drive(0, 1, 0, 1, 2, 0, 0); tick();
    chk("load2", int'(count), 2);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick(); chk("dn1", int'(count), 1);
    tick(); chk("dn0", int'(count), 0);
    chk("tc_dn0", int'(tc), 1);
    tick(); chk("dn4", int'(count), 4);
    chk("dn_wrap", int'(wrap), 1);
    tick(); chk("dn3", int'(count), 3);
    chk("dn_wrap_clr", int'(wrap), 0);

    // Modulus shrink while out of range, up then down
    drive(0, 1, 0, 0, 0, 1, 0); tick();
    drive(0, 1, 0, 1, 6, 0, 0); tick();
    chk("load6", int'(count), 6);
    drive(0, 1, 0, 0, 0, 1, 4); tick();
    chk("mod4", int'(modulus), 4);
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    chk("shrink_up", int'(count), 0);
    chk("shrink_up_wrap", int'(wrap), 1);
    drive(0, 1, 0, 0, 0, 1, 0); tick();
    drive(0, 1, 0, 1, 6, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 1, 4); tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    chk("shrink_dn", int'(count), 3);
    chk("shrink_dn_wrap", int'(wrap), 0);

    // Full 0..7 count with mod_val=0
    drive(0, 1, 1, 0, 0, 1, 0); tick();
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("full_seq", int'(count), i % 8);
    end
    chk("full_wrap", int'(wrap), 1);

    // Load range check and priority
    drive(0, 1, 0, 0, 0, 1, 5); tick();
    drive(0, 1, 0, 1, 3, 0, 0); tick();
    chk("load3", int'(count), 3);
    drive(0, 1, 0, 1, 5, 0, 0); tick();
    chk("load5_rej", int'(count), 3);
    chk("load_err", int'(load_err), 1);
    idle(); tick();
    chk("load_err_clr", int'(load_err), 0);
    drive(1, 1, 1, 1, 2, 0, 0); tick();
    chk("clr_prio", int'(count), 0);

    // Enable hold
    drive(0, 1, 0, 1, 2, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("hold_tc", int'(tc), 0);
      tick();
      chk("hold", int'(count), 2);
      chk("hold_wrap", int'(wrap), 0);
    end

    // M=1
    drive(0, 1, 0, 0, 0, 1, 1); tick();
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("m1_count", int'(count), 0);
      chk("m1_tc", int'(tc), 1);
      chk("m1_wrap", int'(wrap), 1);
    end
    up_dn = 1'b0;
    tick();
    chk("m1_dn_count", int'(count), 0);
    chk("m1_dn_wrap", int'(wrap), 1);

    // Randomized traffic, with occasional asynchronous reset pulses
    for (int n = 0; n < 2000; n++) begin
      if (n % 400 == 399) begin
        reset = 1'b0;
        #1 reset = 1'b1;
      end
      drive(($urandom % 4) != 0, $urandom % 2, ($urandom % 16) == 0,
            ($urandom % 8) == 0, $urandom % 8, ($urandom % 10) == 0, $urandom % 8);
      tick();
    end

    // Cascade: two decade stages
    idle();
    reset = 1'b0;
    #1 reset = 1'b1;
    hi_wraps = 0;
    cas_run = 1'b1;
    cas_en = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    chk("cas50_lo", int'(lo_count), 0);
    chk("cas50_hi", int'(hi_count), 5);
    for (int i = 0; i < 50; i++) tick();
    chk("cas100_lo", int'(lo_count), 0);
    chk("cas100_hi", int'(hi_count), 0);
    #4;
    chk("cas_hi_wraps", hi_wraps, 1);
    cas_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
- Parametrised, runtime-programmable modulo-N counter. Successor to the fixed mod-5 counter.
- Counts up or down through 0..M-1, where M is a modulus register loaded at runtime.
- Supports enable, synchronous clear and parallel load.
- Provides a combinational terminal-count output for cascading, a registered wrap pulse, and a load-error flag.
- Used as the general-purpose divider/sequencer counter across the design.

Parameters:
- WIDTH, 3: width of count, modulus and load value.
- DEFAULT_MOD, 5: modulus value held after reset. Must satisfy 1 <= DEFAULT_MOD <= 2^WIDTH; a value of 2^WIDTH is encoded as 0.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  1 = count up, 0 = count down.
- clr  input  1  synchronous clear of count to 0.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  WIDTH  value written to count on load.
- mod_wr  input  1  write strobe for the modulus register.
- mod_val  input  WIDTH  new modulus; 0 means 2^WIDTH.
- count  output  WIDTH  current count, registered.
- modulus  output  WIDTH  current modulus register contents.
- tc  output  1  terminal count, combinational.
- wrap  output  1  one-cycle registered pulse after a wrap.
- load_err  output  1  one-cycle registered pulse after a rejected load.

Behaviour:
- Clocking and reset:
  - Clock is clk; reset is asynchronous, active-low.
  - On reset low: count=0, modulus=DEFAULT_MOD, wrap=0, load_err=0, all immediately and independent of clk.
- Effective modulus:
  - M = modulus, or 2^WIDTH when modulus==0.
  - All comparisons are unsigned, WIDTH bits. Arithmetic is done in WIDTH+1 bits internally so M-1 never overflows.
- Modulus register:
  - When mod_wr=1 at a rising edge, modulus <= mod_val.
  - The new M governs the next cycle's step, not the same-edge step.
  - mod_wr is independent of clr/load/en and may coincide with any of them.
- Count update priority per rising edge:
  - 1. clr: count <= 0; wrap=0; load_err=0.
  - 2. load:
    - If load_val < M: count <= load_val.
    - Otherwise: count unchanged and load_err=1 for exactly the next cycle.
    - Load is checked against the M in effect before any same-edge mod_wr.
  - 3. en && up_dn:
    - If count == M-1: count <= 0 and wrap=1.
    - If count > M-1 (out of range after the modulus shrank): count <= 0 and wrap=1.
    - Otherwise: count <= count+1.
  - 4. en && !up_dn:
    - If count == 0: count <= M-1 and wrap=1.
    - If count > M-1: count <= M-1 and wrap=0.
    - Otherwise: count <= count-1.
  - 5. Otherwise count holds.
- Pulse flags:
  - wrap and load_err are cleared on any cycle in which they are not set by the rules above, so each pulses exactly one cycle.
- tc:
  - tc = en & (up_dn ? (count >= M-1) : (count == 0)).
  - tc is combinational from the present state and inputs; it is high in the cycle before the edge that wraps.
  - clr or load do not mask tc. A cascaded stage must gate on its own clr.
- M=1 (mod_val=1):
  - count stays 0.
  - Every enabled cycle wraps, so tc=en and wrap pulses continuously while en=1.
- Direction change mid-sequence:
  - Takes effect on the next edge; there is no pipeline.
- Latency:
  - count updates 1 cycle after qualifying inputs.
  - wrap and load_err are asserted in the cycle after the wrap/load edge.

Test Plan:
- Reset/default:
  - Stimulus: WIDTH=3, DEFAULT_MOD=5, en=1, up_dn=1, release reset.
  - Required: count 0,1,2,3,4,0,1; tc high when count=4; wrap pulses 1 cycle when count returns to 0. Assert reset mid-count at 3 → count=0 immediately without a clk edge.
- Down count:
  - Stimulus: up_dn=0 from count=2, M=5.
  - Required: count 2,1,0,4,3; tc high at 0; wrap at the transition to 4.
- Modulus change:
  - Stimulus: at count=6 with M=8, write mod_val=4.
  - Required: next enabled up step gives count=0 with wrap=1.
  - Repeat with up_dn=0: count=6 → 3 with wrap=0.
  - mod_val=0 with WIDTH=3 gives a full 0..7 count.
- Load/priority:
  - Stimulus: M=5, load=1, load_val=3.
  - Required: count=3. Then load_val=5 → count unchanged and load_err=1 for one cycle. Then clr=1, load=1, en=1 together → count=0.
- Enable hold and M=1:
  - Stimulus: en=0 for 4 cycles.
  - Required: count holds, tc=0, no wrap.
  - Then mod_val=1, en=1 → count stays 0, tc=1 and wrap=1 every cycle.
- Cascade:
  - Stimulus: two instances with WIDTH=4 and M=10; the high stage's en is driven by the low stage's tc.
  - Required: after 100 clocks both stages read 0, and the high stage has wrapped once.
